// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset PC and the fetch-queue entry.
package cpu_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = '0;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/grant and in-order response bus.
interface fetch_queue_if #(parameter int XLEN = cpu_pkg::XLEN);
   logic            imemReq;
   logic [XLEN-1:0] imemAddr;
   logic            imemGnt;
   logic            imemRValid;
   logic [XLEN-1:0] imemRData;

   modport master (output imemReq, imemAddr, input imemGnt, imemRValid, imemRData);
   modport slave  (input imemReq, imemAddr, output imemGnt, imemRValid, imemRData);
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries; pointers wrap modulo DEPTH (power of two).
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + PW'(1);
         end
         if (pop) head_d = head_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Storage is reset too so the head outputs read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[head_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: sequential address issue with credit control, wrong-path discard on
// redirect, and an in-order queue feeding decode.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic             clk,
   input  logic             rst_n,
   fetch_queue_if.master    imem,
   output logic [XLEN-1:0]  instrF,
   output logic [XLEN-1:0]  pcF,
   output logic [XLEN-1:0]  pcPlus4F,
   output logic             validF,
   input  logic             stallD,
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirectPC
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc_q, tag_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d;
   logic [CW-1:0]   count;
   logic            imem_req, issue, resp, push, pop;
   fetch_entry_t    head, push_entry;

   always_comb begin
      // Credit covers both queued entries and outstanding requests, so a push never finds the queue full.
      imem_req   = rst_n && !redirect &&
                   (({1'b0, count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
      issue      = imem_req && imem.imemGnt;
      resp       = imem.imemRValid && (inflight_q != '0);
      push       = resp && !redirect && (discard_q == '0);
      pop        = validF && !stallD && !redirect;
      push_entry = '{instr: imem.imemRData, pc: tag_pc_q};

      inflight_d = inflight_q + CW'(issue) - CW'(resp);
      discard_d  = discard_q;
      fetch_pc_d = fetch_pc_q;
      tag_pc_d   = tag_pc_q;
      if (redirect) begin
         discard_d  = inflight_q - CW'(resp);
         fetch_pc_d = redirectPC;
         tag_pc_d   = redirectPC;
      end else begin
         if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
         if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (push)  tag_pc_d   = tag_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         tag_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tag_pc_q   <= tag_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect),
      .head       (head),
      .count      (count)
   );

   assign imem.imemReq  = imem_req;
   assign imem.imemAddr = fetch_pc_q;
   assign validF        = (count != '0);
   assign instrF        = head.instr;
   assign pcF           = head.pc;
   assign pcPlus4F      = head.pc + XLEN'(4);

   // A response with nothing outstanding is ignored by the logic above.
   imem_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst_n)
      imem.imemRValid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: in-order variable-latency memory model plus an
// abstract PC-stream reference for what decode must see.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instrF, pcF, pcPlus4F, redirectPC;
   logic        validF, stallD, redirect;

   fetch_queue_if #(.XLEN(32)) ifc ();

   fetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem       (ifc),
      .instrF     (instrF),
      .pcF        (pcF),
      .pcPlus4F   (pcPlus4F),
      .validF     (validF),
      .stallD     (stallD),
      .redirect   (redirect),
      .redirectPC (redirectPC)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdr;
      logic [31:0] rpc;
      logic        req;
      logic        grant;
      logic [31:0] addr;
      logic        rv;
      logic        vf;
      logic        pop;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] p4;
   } cyc_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   cyc_t        lg[$];
   mreq_t       mq[$];
   int          cyc, last_due, lat_cur;
   logic        gnt_cur, stall_cur, rdr_cur;
   logic [31:0] rpc_cur;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // One clock of stimulus: drive at negedge, sample 1 time unit later, log the cycle.
   task automatic step();
      cyc_t e;
      int   due;
      @(negedge clk);
      ifc.imemGnt = gnt_cur;
      stallD      = stall_cur;
      redirect    = rdr_cur;
      redirectPC  = rpc_cur;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         ifc.imemRValid = 1'b1;
         ifc.imemRData  = mem_f(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         ifc.imemRValid = 1'b0;
         ifc.imemRData  = $urandom;
      end
      #1;
      e.rdr   = rdr_cur;
      e.rpc   = rpc_cur;
      e.req   = ifc.imemReq;
      e.grant = ifc.imemReq && gnt_cur;
      e.addr  = ifc.imemAddr;
      e.rv    = ifc.imemRValid;
      e.vf    = validF;
      e.pop   = validF && !stall_cur && !rdr_cur;
      e.pc    = pcF;
      e.instr = instrF;
      e.p4    = pcPlus4F;
      if (e.grant === 1'b1) begin
         due = cyc + lat_cur;
         if (due < last_due) due = last_due;
         last_due = due;
         mq.push_back('{addr: ifc.imemAddr, due: due});
      end
      lg.push_back(e);
      cyc++;
   endtask

   task automatic idle_inputs();
      ifc.imemGnt    = 1'b0;
      ifc.imemRValid = 1'b0;
      ifc.imemRData  = '0;
      stallD         = 1'b0;
      redirect       = 1'b0;
      redirectPC     = '0;
      gnt_cur   = 1'b1;
      stall_cur = 1'b0;
      rdr_cur   = 1'b0;
      rpc_cur   = '0;
      lat_cur   = 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      lg.delete();
      mq.delete();
      cyc      = 0;
      last_due = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      @(negedge clk);
      #1;
      checks++; if (ifc.imemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", ifc.imemReq); end
      checks++; if (ifc.imemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", ifc.imemAddr); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_validF got %b want 0", validF); end
      checks++; if (instrF !== 32'h0) begin errors++; $display("FAIL reset_instrF got %h want 0", instrF); end
      checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pcF got %h want 0", pcF); end
      checks++; if (pcPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pcPlus4F got %h want 4", pcPlus4F); end
      do_reset();
      step();
      checks++; if (lg[0].req !== 1'b1 || lg[0].addr !== 32'h0) begin
         errors++; $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", lg[0].req, lg[0].addr);
      end
   endtask

   task automatic test_stream();
      do_reset();
      repeat (20) step();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (lg[i].grant !== 1'b1 || lg[i].addr !== 32'(4*i)) begin
            errors++; $display("FAIL stream_addr c%0d got grant=%b addr=%h want grant=1 addr=%h", i, lg[i].grant, lg[i].addr, 32'(4*i));
         end
      end
      checks++; if (lg[0].vf !== 1'b0 || lg[1].vf !== 1'b0) begin
         errors++; $display("FAIL stream_early_valid got %b%b want 00", lg[0].vf, lg[1].vf);
      end
      for (int i = 2; i < 20; i++) begin
         checks++;
         if (lg[i].vf !== 1'b1 || lg[i].pc !== 32'(4*(i-2)) || lg[i].instr !== mem_f(32'(4*(i-2))) ||
             lg[i].p4 !== 32'(4*(i-1))) begin
            errors++; $display("FAIL stream_pop c%0d got v=%b pc=%h instr=%h p4=%h want v=1 pc=%h instr=%h",
                               i, lg[i].vf, lg[i].pc, lg[i].instr, lg[i].p4, 32'(4*(i-2)), mem_f(32'(4*(i-2))));
         end
      end
   endtask

   task automatic test_stall();
      int          ngr, npop;
      logic [31:0] exp_pc, exp_f;
      do_reset();
      stall_cur = 1'b1;
      repeat (10) step();
      ngr = 0;
      foreach (lg[i]) if (lg[i].grant === 1'b1) ngr++;
      checks++; if (ngr != 4) begin errors++; $display("FAIL stall_grants got %0d want 4", ngr); end
      checks++; if (lg[9].req !== 1'b0) begin errors++; $display("FAIL stall_req_low got %b want 0", lg[9].req); end
      stall_cur = 1'b0;
      step();
      step();
      checks++; if (lg[11].grant !== 1'b1) begin errors++; $display("FAIL stall_resume got grant=%b want 1", lg[11].grant); end
      repeat (20) step();
      exp_pc = 32'h0; exp_f = 32'h0; npop = 0;
      foreach (lg[i]) begin
         if (lg[i].grant === 1'b1) begin
            checks++; if (lg[i].addr !== exp_f) begin errors++; $display("FAIL stall_addr c%0d got %h want %h", i, lg[i].addr, exp_f); end
            exp_f += 32'd4;
         end
         if (lg[i].pop === 1'b1) begin
            checks++; npop++;
            if (lg[i].pc !== exp_pc || lg[i].instr !== mem_f(exp_pc)) begin
               errors++; $display("FAIL stall_seq c%0d got pc=%h instr=%h want pc=%h instr=%h", i, lg[i].pc, lg[i].instr, exp_pc, mem_f(exp_pc));
            end
            exp_pc += 32'd4;
         end
      end
      checks++; if (npop < 20) begin errors++; $display("FAIL stall_popcount got %0d want >=20", npop); end
   endtask

   task automatic test_redirect();
      int first;
      do_reset();
      lat_cur = 3;
      step(); step();
      gnt_cur = 1'b0; rdr_cur = 1'b1; rpc_cur = 32'h100;
      step();
      gnt_cur = 1'b1; rdr_cur = 1'b0;
      repeat (12) step();
      checks++; if (lg[2].req !== 1'b0) begin errors++; $display("FAIL redir_req got %b want 0", lg[2].req); end
      checks++; if (lg[3].vf !== 1'b0) begin errors++; $display("FAIL redir_valid_next got %b want 0", lg[3].vf); end
      checks++; if (lg[3].grant !== 1'b1 || lg[3].addr !== 32'h100) begin
         errors++; $display("FAIL redir_first_req got grant=%b addr=%h want grant=1 addr=100", lg[3].grant, lg[3].addr);
      end
      first = -1;
      for (int i = 3; i < 15; i++) if (first < 0 && lg[i].vf === 1'b1) first = i;
      checks++; if (first != 7) begin errors++; $display("FAIL redir_latency got cycle %0d want 7", first); end
      if (first >= 0) begin
         checks++;
         if (lg[first].pc !== 32'h100 || lg[first].p4 !== 32'h104 || lg[first].instr !== mem_f(32'h100)) begin
            errors++; $display("FAIL redir_head got pc=%h p4=%h instr=%h want pc=100 p4=104 instr=%h",
                               lg[first].pc, lg[first].p4, lg[first].instr, mem_f(32'h100));
         end
      end
   endtask

   task automatic test_redirect_collide();
      logic [31:0] exp_pc;
      do_reset();
      repeat (5) step();
      rdr_cur = 1'b1; rpc_cur = 32'h200;
      step();
      rdr_cur = 1'b0;
      repeat (10) step();
      checks++; if (lg[5].rv !== 1'b1 || lg[5].vf !== 1'b1) begin
         errors++; $display("FAIL collide_setup got rv=%b vf=%b want 1 1", lg[5].rv, lg[5].vf);
      end
      checks++; if (lg[6].vf !== 1'b0) begin errors++; $display("FAIL collide_valid_next got %b want 0", lg[6].vf); end
      checks++; if (lg[8].vf !== 1'b1 || lg[8].pc !== 32'h200) begin
         errors++; $display("FAIL collide_first got vf=%b pc=%h want vf=1 pc=200", lg[8].vf, lg[8].pc);
      end
      exp_pc = 32'h0;
      foreach (lg[i]) begin
         if (lg[i].pop === 1'b1) begin
            checks++;
            if (lg[i].pc !== exp_pc || lg[i].instr !== mem_f(exp_pc)) begin
               errors++; $display("FAIL collide_seq c%0d got pc=%h instr=%h want pc=%h instr=%h", i, lg[i].pc, lg[i].instr, exp_pc, mem_f(exp_pc));
            end
            exp_pc += 32'd4;
         end
         if (lg[i].rdr === 1'b1) exp_pc = lg[i].rpc;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc, exp_f;
      bit          seen;
      do_reset();
      step();
      rdr_cur = 1'b1; rpc_cur = 32'hFFFF_FFF8;
      step();
      rdr_cur = 1'b0;
      repeat (12) step();
      exp_pc = 32'h0; exp_f = 32'h0; seen = 1'b0;
      foreach (lg[i]) begin
         if (lg[i].grant === 1'b1) begin
            checks++; if (lg[i].addr !== exp_f) begin errors++; $display("FAIL wrap_addr c%0d got %h want %h", i, lg[i].addr, exp_f); end
            exp_f += 32'd4;
         end
         if (lg[i].pop === 1'b1) begin
            checks++;
            if (lg[i].pc !== exp_pc || lg[i].instr !== mem_f(exp_pc) || lg[i].p4 !== exp_pc + 32'd4) begin
               errors++; $display("FAIL wrap_seq c%0d got pc=%h p4=%h want pc=%h p4=%h", i, lg[i].pc, lg[i].p4, exp_pc, exp_pc + 32'd4);
            end
            if (lg[i].pc === 32'hFFFF_FFFC) seen = 1'b1;
            exp_pc += 32'd4;
         end
         if (lg[i].rdr === 1'b1) begin exp_pc = lg[i].rpc; exp_f = lg[i].rpc; end
      end
      checks++; if (!seen) begin errors++; $display("FAIL wrap_seen got no pop of FFFFFFFC want one"); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, exp_f;
      int          npop;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         gnt_cur   = ($urandom_range(0, 3) != 0);
         stall_cur = ($urandom_range(0, 3) == 0);
         lat_cur   = $urandom_range(1, 4);
         rdr_cur   = ($urandom_range(0, 24) == 0);
         rpc_cur   = $urandom;
         rpc_cur[1:0] = 2'b00;
         step();
      end
      rdr_cur = 1'b0;
      exp_pc = 32'h0; exp_f = 32'h0; npop = 0;
      foreach (lg[i]) begin
         if (lg[i].grant === 1'b1) begin
            checks++; if (lg[i].addr !== exp_f) begin errors++; $display("FAIL rand_addr c%0d got %h want %h", i, lg[i].addr, exp_f); end
            exp_f += 32'd4;
         end
         if (lg[i].pop === 1'b1) begin
            checks++; npop++;
            if (lg[i].pc !== exp_pc || lg[i].instr !== mem_f(exp_pc) || lg[i].p4 !== exp_pc + 32'd4) begin
               errors++; $display("FAIL rand_seq c%0d got pc=%h instr=%h p4=%h want pc=%h instr=%h",
                                  i, lg[i].pc, lg[i].instr, lg[i].p4, exp_pc, mem_f(exp_pc));
            end
            exp_pc += 32'd4;
         end
         if (lg[i].rdr === 1'b1) begin
            checks++; if (lg[i].req !== 1'b0) begin errors++; $display("FAIL rand_redir_req c%0d got %b want 0", i, lg[i].req); end
            if (i + 1 < lg.size()) begin
               checks++; if (lg[i+1].vf !== 1'b0) begin errors++; $display("FAIL rand_redir_valid c%0d got %b want 0", i + 1, lg[i+1].vf); end
            end
            exp_pc = lg[i].rpc; exp_f = lg[i].rpc;
         end
      end
      checks++; if (npop < 40) begin errors++; $display("FAIL rand_progress got %0d pops want >=40", npop); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_pc, exp_f;
      int          npop;
      do_reset();
      stall_cur = 1'b1;
      repeat (3) step();
      lat_cur = 10;
      step();
      gnt_cur = 1'b0;
      step();
      checks++; if (lg[4].vf !== 1'b1 || lg[4].req !== 1'b0) begin
         errors++; $display("FAIL rmid_setup got vf=%b req=%b want vf=1 req=0", lg[4].vf, lg[4].req);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ifc.imemReq !== 1'b0 || ifc.imemAddr !== 32'h0 || validF !== 1'b0 || instrF !== 32'h0 ||
          pcF !== 32'h0 || pcPlus4F !== 32'h4) begin
         errors++; $display("FAIL rmid_outputs got req=%b addr=%h vf=%b instr=%h pc=%h p4=%h want 0 0 0 0 0 4",
                            ifc.imemReq, ifc.imemAddr, validF, instrF, pcF, pcPlus4F);
      end
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      lg.delete(); mq.delete(); cyc = 0; last_due = 0;
      repeat (12) step();
      exp_pc = 32'h0; exp_f = 32'h0; npop = 0;
      checks++; if (lg[0].grant !== 1'b1) begin errors++; $display("FAIL rmid_restart got grant=%b want 1", lg[0].grant); end
      foreach (lg[i]) begin
         if (lg[i].grant === 1'b1) begin
            checks++; if (lg[i].addr !== exp_f) begin errors++; $display("FAIL rmid_addr c%0d got %h want %h", i, lg[i].addr, exp_f); end
            exp_f += 32'd4;
         end
         if (lg[i].pop === 1'b1) begin
            checks++; npop++;
            if (lg[i].pc !== exp_pc || lg[i].instr !== mem_f(exp_pc)) begin
               errors++; $display("FAIL rmid_seq c%0d got pc=%h instr=%h want pc=%h instr=%h", i, lg[i].pc, lg[i].instr, exp_pc, mem_f(exp_pc));
            end
            exp_pc += 32'd4;
         end
      end
      checks++; if (npop < 8) begin errors++; $display("FAIL rmid_popcount got %0d want >=8", npop); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_collide();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end that sits directly upstream of the pipelined CPU's decode stage. It generates sequential instruction addresses and issues them to a variable-latency instruction memory over a request/grant handshake. It tracks in-flight requests and buffers returned instructions in a small in-order queue. It presents {instruction, PC, PC+4} to decode, honours the decode stall, and discards wrong-path fetches when the execute stage redirects the PC on a taken branch or jump.

## Interface
- DEPTH, 4, queue entries; also the cap on queued plus in-flight fetches; power of two, at least 2
- XLEN, 32, address/instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imemReq  out  1  fetch request valid
- imemAddr  out  XLEN  fetch address, word aligned
- imemGnt  in  1  memory accepts request this cycle
- imemRValid  in  1  response valid; responses return in request order
- imemRData  in  XLEN  returned instruction
- instrF  out  XLEN  head instruction
- pcF  out  XLEN  head PC
- pcPlus4F  out  XLEN  head PC + 4
- validF  out  1  head entry valid
- stallD  in  1  decode not consuming this cycle
- redirect  in  1  execute-stage PC redirect (PCSrcE != 0)
- redirectPC  in  XLEN  redirect target

## Operation
- Issue: imemReq = !redirect && (count + inflight < DEPTH). A request is issued when imemReq && imemGnt. On issue, fetchPC <= fetchPC + 4, inflight++.
- imemAddr = fetchPC. Address and request are held stable until granted.
- Response: when imemRValid, inflight--. If discard > 0, discard-- and the data is dropped. Otherwise {imemRData, tagPC} is pushed and tagPC <= tagPC + 4. tagPC is the PC of the oldest non-discarded in-flight request.
- Pop: when validF && !stallD && !redirect, the head is removed.
- Redirect (single cycle):
  - queue emptied; fetchPC <= redirectPC; tagPC <= redirectPC
  - discard <= inflight after this cycle's response is accounted for, so every request still in flight is dropped
  - a response arriving in the redirect cycle is dropped
- Push and pop in the same cycle are both performed and count is unchanged.
- Credit rule: count + inflight <= DEPTH always, so a push never meets a full queue. Overflow is therefore impossible and needs no handling.
- imemRValid with inflight == 0 is a protocol error. Ignore it and flag it with an assertion.
- Arithmetic: PC arithmetic is modulo 2^XLEN and wraps silently. count, inflight and discard are $clog2(DEPTH)+1 bits wide. discard <= inflight always.

## Timing
- Reset values:
  - outputs: imemReq 0, imemAddr RESET_PC, validF 0, instrF 0, pcF 0, pcPlus4F 4
  - internal: fetchPC = tagPC = RESET_PC; count = inflight = discard = 0
- First request is asserted in the first cycle after rst_n deasserts.
- Minimum fetch latency:
  - grant at cycle t, earliest imemRValid at t+1
  - pushed at the end of t+1, validF at t+2
  - there is no memory-to-decode bypass
- Queue outputs come straight from the head entry register. They depend combinationally only on head state, not on stallD or redirect.
- Redirect at cycle t:
  - validF is 0 at t+1
  - imemReq is low at t, and the first request for redirectPC is at t+1
  - the earliest redirected instruction is at t+3 plus (number of dropped in-flight responses)
- Reset mid-operation: asynchronous clear of all state. In-flight responses arriving after reset are outside the protocol; the memory is reset together with this block.
- Sustained throughput is 1 instruction/cycle when imemGnt is held at 1, latency is 1, and DEPTH >= 3.

## Structure
- Shared package cpu_pkg holds XLEN, RESET_PC default, and the fetch-entry struct {instr, pc}.
- One sub-module, fetch_fifo: DEPTH-entry circular buffer with head/tail pointers that wrap modulo DEPTH, a count, and push/pop/flush ports. The issue/credit/discard logic stays in fetch_queue.

## Test plan
- Reset, imemGnt=1, latency 1, stallD=0 → addresses 0,4,8,… one per cycle; validF from cycle 2 with pcF=0, instrF = mem[0]; no bubbles.
- stallD=1 held, DEPTH=4 → exactly 4 requests granted, imemReq then low; releasing stallD resumes issue within 1 cycle; no instruction lost or duplicated.
- Two requests in flight (latency 3), redirect to 0x100 → both responses dropped, next validF has pcF=0x100, pcPlus4F=0x104.
- Redirect in the same cycle as imemRValid and a pop → response dropped, pop suppressed, validF=0 next cycle.
- fetchPC = 0xFFFFFFFC → next address 0x00000000; pcPlus4F of that entry = 0.
- rst_n asserted with 3 entries queued and 1 in flight → all outputs at reset values immediately; after release the fetch restarts at RESET_PC.
